// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer slice.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package reset_seq_pkg;

    // Sequencer top-level state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Bits needed to hold values 0..n (stage index reaches n in DONE)
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < (n + 1)) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/seq_stage_timer.sv
// Per-stage dwell timer: latches a length on load, counts while enabled, flags the last cycle.
// Latency: expire is combinational on the registered count; load/en take effect at the next edge.
// Backpressure: none; en low simply freezes the count.
module seq_stage_timer
    import reset_seq_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    input  logic             en,
    output logic             expire
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_len;

    // Load restarts the count with a fresh length (zero length behaves as one cycle)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_len <= CNT_W'(1);
        end else if (load) begin
            r_cnt <= '0;
            r_len <= (len == '0) ? CNT_W'(1) : len;
        end else if (en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // The owner stops enabling once expire is seen, so the count never passes r_len-1
    assign expire = (r_cnt == r_len - CNT_W'(1));

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES block resets one at a time, each stage ending on dwell timeout or block ack.
// Latency: start at edge t puts stage 0 out after t; DONE after sum of stage lengths with no ack/hold.
// Backpressure: hold freezes the dwell counter in RUN; an ack still ends the stage while held.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int  NUM_STAGES = 5,
    parameter int  CNT_W      = 32,
    parameter bit  USE_ACK    = 1'b0,
    localparam int IDX_W      = idx_width(NUM_STAGES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        hold,
    input  logic [NUM_STAGES*CNT_W-1:0] stage_len,
    input  logic [NUM_STAGES-1:0]       stage_ack,
    output logic [NUM_STAGES-1:0]       blk_rst,
    output logic [IDX_W-1:0]            stage_idx,
    output logic                        busy,
    output logic                        done,
    output logic                        stage_pulse
);

    seq_state_t            r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_STAGES-1:0] r_blk_rst;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pulse;

    logic                  w_ack_cur;
    logic                  w_expire;
    logic                  w_adv;
    logic                  w_last;
    logic                  w_load;
    logic                  w_en;
    logic [IDX_W-1:0]      w_load_idx;
    logic [CNT_W-1:0]      w_load_len;
    logic [NUM_STAGES-1:0] w_load_mask;

    // Pick the ack of the current stage only; acks from other blocks are ignored
    always_comb begin
        w_ack_cur = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_ack_cur = stage_ack[k];
            end
        end
    end

    assign w_last = (r_idx == IDX_W'(NUM_STAGES - 1));
    assign w_adv  = (r_state == RUN) && ((w_expire && !hold) || (USE_ACK && w_ack_cur));

    // Timer is reloaded on any stage entry (and cleared on abort); otherwise counts in RUN unless held
    assign w_load     = abort || start || (w_adv && !w_last);
    assign w_en       = (r_state == RUN) && !hold && !w_load && !w_adv;
    assign w_load_idx = (abort || start) ? '0 : (r_idx + IDX_W'(1));

    // Length of the stage being entered, and the reset mask that stage presents
    always_comb begin
        w_load_len  = '0;
        w_load_mask = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (w_load_idx == IDX_W'(k)) begin
                w_load_len = stage_len[k*CNT_W +: CNT_W];
            end
            w_load_mask[k] = (IDX_W'(k) >= w_load_idx);
        end
    end

    seq_stage_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (w_load),
        .len    (w_load_len),
        .en     (w_en),
        .expire (w_expire)
    );

    // Sequencer FSM with registered outputs; priority rst > abort > start > advance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_blk_rst <= '1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pulse   <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (abort) begin
                r_state   <= IDLE;
                r_idx     <= '0;
                r_blk_rst <= '1;
                r_busy    <= 1'b0;
                r_done    <= 1'b0;
            end else if (start) begin
                r_state   <= RUN;
                r_idx     <= '0;
                r_blk_rst <= '1;
                r_busy    <= 1'b1;
                r_done    <= 1'b0;
            end else if (w_adv) begin
                r_pulse <= 1'b1;
                if (w_last) begin
                    r_state   <= DONE;
                    r_idx     <= IDX_W'(NUM_STAGES);
                    r_blk_rst <= '0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                end else begin
                    r_idx     <= w_load_idx;
                    r_blk_rst <= w_load_mask;
                end
            end
        end
    end

    assign blk_rst     = r_blk_rst;
    assign stage_idx   = r_idx;
    assign busy        = r_busy;
    assign done        = r_done;
    assign stage_pulse = r_pulse;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: two instances (ack ignored / ack honoured) on shared stimulus.
// A stage/remaining-cycles reference model is compared every cycle; tasks add directed timing checks.
module tb_reset_sequencer;

    localparam int N  = 5;
    localparam int W  = 8;
    localparam int IW = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic           hold = 1'b0;
    logic [N*W-1:0] stage_len = '0;
    logic [N-1:0]   stage_ack = '0;

    logic [N-1:0]   blk_o   [2];
    logic [IW-1:0]  idx_o   [2];
    logic           busy_o  [2];
    logic           done_o  [2];
    logic           pulse_o [2];

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    reset_sequencer #(.NUM_STAGES(N), .CNT_W(W), .USE_ACK(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold),
        .stage_len(stage_len), .stage_ack(stage_ack),
        .blk_rst(blk_o[0]), .stage_idx(idx_o[0]), .busy(busy_o[0]),
        .done(done_o[0]), .stage_pulse(pulse_o[0])
    );

    reset_sequencer #(.NUM_STAGES(N), .CNT_W(W), .USE_ACK(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold),
        .stage_len(stage_len), .stage_ack(stage_ack),
        .blk_rst(blk_o[1]), .stage_idx(idx_o[1]), .busy(busy_o[1]),
        .done(done_o[1]), .stage_pulse(pulse_o[1])
    );

    // Reference model: stage -1 = idle, 0..N-1 = running, N = done; rem = cycles left in stage
    int m_stage [2];
    int m_rem   [2];
    bit m_pulse [2];
    bit mon_en = 1'b0;

    function automatic int len_of(input int k);
        int v;
        v = int'(stage_len[k*W +: W]);
        return (v == 0) ? 1 : v;
    endfunction

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            m_pulse[u] = 1'b0;
            if (rst || abort) begin
                m_stage[u] = -1;
            end else if (start) begin
                m_stage[u] = 0;
                m_rem[u]   = len_of(0);
            end else if (m_stage[u] >= 0 && m_stage[u] < N) begin
                if ((u == 1 && stage_ack[m_stage[u]]) || (m_rem[u] == 1 && !hold)) begin
                    m_pulse[u] = 1'b1;
                    m_stage[u] = m_stage[u] + 1;
                    if (m_stage[u] < N) m_rem[u] = len_of(m_stage[u]);
                end else if (!hold) begin
                    m_rem[u] = m_rem[u] - 1;
                end
            end
        end
        mon_en = 1'b1;
    end

    // Cycle-by-cycle scoreboard on the falling edge
    always @(negedge clk) begin
        if (mon_en) begin
            for (int u = 0; u < 2; u++) begin
                logic [N-1:0]  eb;
                logic [IW-1:0] ei;
                logic          ebusy, edone;
                for (int j = 0; j < N; j++) eb[j] = (j >= m_stage[u]);
                ei    = (m_stage[u] < 0) ? '0 : IW'(m_stage[u]);
                ebusy = (m_stage[u] >= 0 && m_stage[u] < N);
                edone = (m_stage[u] == N);
                vectors += 5;
                if (blk_o[u] !== eb) begin
                    errors++;
                    $display("FAIL mon_blk_rst u%0d t=%0t got %b exp %b", u, $time, blk_o[u], eb);
                end
                if (idx_o[u] !== ei) begin
                    errors++;
                    $display("FAIL mon_stage_idx u%0d t=%0t got %0d exp %0d", u, $time, idx_o[u], ei);
                end
                if (busy_o[u] !== ebusy) begin
                    errors++;
                    $display("FAIL mon_busy u%0d t=%0t got %b exp %b", u, $time, busy_o[u], ebusy);
                end
                if (done_o[u] !== edone) begin
                    errors++;
                    $display("FAIL mon_done u%0d t=%0t got %b exp %b", u, $time, done_o[u], edone);
                end
                if (pulse_o[u] !== m_pulse[u]) begin
                    errors++;
                    $display("FAIL mon_pulse u%0d t=%0t got %b exp %b", u, $time, pulse_o[u], m_pulse[u]);
                end
            end
        end
    end

    // Trace of blk_rst for instance under watch, one entry per cycle after the start edge
    logic [N-1:0] tr [$];

    // Pulse start, then sample each cycle until done or limit; optional hold window in cycles
    task automatic start_and_watch(input int u, input int hold_on, input int hold_off,
                                   input int limit, output int cyc, output int pulses);
        int c;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        c = 0;
        pulses = 0;
        tr.delete();
        forever begin
            tr.push_back(blk_o[u]);
            pulses += int'(pulse_o[u]);
            if (done_o[u] === 1'b1 || c >= limit) break;
            if (c == hold_on)  hold = 1'b1;
            if (c == hold_off) hold = 1'b0;
            @(negedge clk);
            c++;
        end
        hold = 1'b0;
        cyc = c;
    endtask

    task automatic set_all_len(input int v);
        for (int k = 0; k < N; k++) stage_len[k*W +: W] = W'(v);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (blk_o[0] !== 5'b11111 || done_o[0] !== 1'b0 || busy_o[0] !== 1'b0 || idx_o[0] !== 3'd0) begin
            errors++;
            $display("FAIL reset_state got blk=%b done=%b busy=%b idx=%0d exp blk=11111 done=0 busy=0 idx=0",
                     blk_o[0], done_o[0], busy_o[0], idx_o[0]);
        end
        rst = 1'b0;
        repeat (6) @(negedge clk);
        vectors++;
        if (blk_o[1] !== 5'b11111 || busy_o[1] !== 1'b0 || idx_o[1] !== 3'd0) begin
            errors++;
            $display("FAIL reset_hold got blk=%b busy=%b idx=%0d exp blk=11111 busy=0 idx=0",
                     blk_o[1], busy_o[1], idx_o[1]);
        end
    endtask

    task automatic test_nominal();
        int cyc, pulses, bad;
        logic [N-1:0] exp_b;
        set_all_len(4);
        start_and_watch(0, -1, -1, 200, cyc, pulses);
        vectors++;
        if (cyc != 20) begin errors++; $display("FAIL nominal_done_time got %0d exp 20", cyc); end
        vectors++;
        if (pulses != 5) begin errors++; $display("FAIL nominal_pulses got %0d exp 5", pulses); end
        bad = 0;
        for (int c = 0; c < 20 && c < tr.size(); c++) begin
            exp_b = 5'b11111 << (c / 4);
            if (tr[c] !== exp_b) bad++;
        end
        vectors++;
        if (bad != 0) begin errors++; $display("FAIL nominal_blk_seq got %0d bad cycles exp 0", bad); end
        vectors++;
        if (blk_o[0] !== 5'b00000 || idx_o[0] !== 3'd5) begin
            errors++;
            $display("FAIL nominal_done_out got blk=%b idx=%0d exp blk=00000 idx=5", blk_o[0], idx_o[0]);
        end
    endtask

    task automatic test_len_zero();
        int cyc, pulses;
        set_all_len(3);
        stage_len[2*W +: W] = '0;
        start_and_watch(0, -1, -1, 200, cyc, pulses);
        vectors++;
        if (cyc != 13) begin errors++; $display("FAIL lenzero_done_time got %0d exp 13", cyc); end
        vectors++;
        if (tr.size() < 8 || tr[6] !== 5'b11100 || tr[7] !== 5'b11000) begin
            errors++;
            $display("FAIL lenzero_stage2 got size=%0d exp stage2 only at cycle 6", tr.size());
        end
    endtask

    task automatic test_hold();
        int cyc, pulses, n1;
        set_all_len(4);
        start_and_watch(0, 5, 11, 200, cyc, pulses);
        vectors++;
        if (cyc != 26) begin errors++; $display("FAIL hold_done_time got %0d exp 26", cyc); end
        n1 = 0;
        foreach (tr[i]) if (tr[i] === 5'b11110) n1++;
        vectors++;
        if (n1 != 10) begin errors++; $display("FAIL hold_stage1_len got %0d exp 10", n1); end
    endtask

    task automatic test_ack();
        set_all_len(100);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        stage_ack = 5'b01000;
        @(negedge clk);
        vectors++;
        if (idx_o[1] !== 3'd0) begin errors++; $display("FAIL ack_other_ignored got %0d exp 0", idx_o[1]); end
        stage_ack = 5'b01001;
        @(negedge clk);
        vectors++;
        if (idx_o[1] !== 3'd1 || pulse_o[1] !== 1'b1 || idx_o[0] !== 3'd0) begin
            errors++;
            $display("FAIL ack_stage0 got idx1=%0d pulse1=%b idx0=%0d exp 1 1 0", idx_o[1], pulse_o[1], idx_o[0]);
        end
        hold = 1'b1;
        stage_ack = 5'b00010;
        @(negedge clk);
        vectors++;
        if (idx_o[1] !== 3'd2 || blk_o[1] !== 5'b11100) begin
            errors++;
            $display("FAIL ack_under_hold got idx=%0d blk=%b exp idx=2 blk=11100", idx_o[1], blk_o[1]);
        end
        hold = 1'b0;
        stage_ack = '0;
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
    endtask

    task automatic test_abort();
        set_all_len(4);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (13) @(negedge clk);
        vectors++;
        if (idx_o[0] !== 3'd3) begin errors++; $display("FAIL abort_pre_stage got %0d exp 3", idx_o[0]); end
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        vectors++;
        if (blk_o[0] !== 5'b11111 || busy_o[0] !== 1'b0 || idx_o[0] !== 3'd0) begin
            errors++;
            $display("FAIL abort_idle got blk=%b busy=%b idx=%0d exp 11111 0 0", blk_o[0], busy_o[0], idx_o[0]);
        end
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        vectors++;
        if (busy_o[0] !== 1'b0 || blk_o[0] !== 5'b11111) begin
            errors++;
            $display("FAIL start_abort_same got busy=%b blk=%b exp 0 11111", busy_o[0], blk_o[0]);
        end
    endtask

    task automatic test_restart();
        int cyc, pulses;
        set_all_len(2);
        start_and_watch(0, -1, -1, 200, cyc, pulses);
        vectors++;
        if (cyc != 10 || done_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL restart_first_run got %0d done=%b exp 10 1", cyc, done_o[0]);
        end
        set_all_len(3);
        start_and_watch(0, -1, -1, 200, cyc, pulses);
        vectors++;
        if (cyc != 15) begin errors++; $display("FAIL restart_done_time got %0d exp 15", cyc); end
        vectors++;
        if (tr.size() < 4 || tr[0] !== 5'b11111 || tr[2] !== 5'b11111 || tr[3] !== 5'b11110) begin
            errors++;
            $display("FAIL restart_fresh_dwell got size=%0d exp stage0 for 3 cycles", tr.size());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) begin
                for (int k = 0; k < N; k++) stage_len[k*W +: W] = W'($urandom_range(0, 5));
            end
            start     = ($urandom_range(0, 39) == 0);
            abort     = ($urandom_range(0, 79) == 0);
            hold      = ($urandom_range(0, 4) == 0);
            stage_ack = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        hold = 1'b0;
        stage_ack = '0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_len_zero();
        test_hold();
        test_ack();
        test_abort();
        test_restart();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
